// File: rtl/loader_pkg.sv
// Shared types and default constants for the UART program loader.
// The GET_SUM state exists only when UART_PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int SIZE_BYTES = 4;

  localparam logic [7:0] BOOT_BYTE = 8'h99;
  localparam logic [7:0] DONE_BYTE = 8'haa;
  localparam logic [7:0] ERR_BYTE  = 8'h55;

  typedef enum logic [2:0] {
    S_SEND_BOOT,
    S_GET_SIZE,
    S_GET_PROG,
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    S_GET_SUM,
`endif
    S_SEND_DONE,
    S_STREAM,
    S_ERROR
  } state_t;

endpackage

// File: rtl/uart_program_loader_if.sv
// Word output stream of the loader.
// A word transfers on a clock edge where out_valid && out_ready; the head
// stays stable while out_valid is high and out_ready is low.
interface uart_program_loader_if #(
  parameter int WORD_BYTES = 4
);
  logic                      out_valid;
  logic                      out_ready;
  logic [8*WORD_BYTES-1:0]   out_data;
  logic                      out_is_instr;

  modport master (output out_valid, output out_data, output out_is_instr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_is_instr, output out_ready);
endinterface

// File: rtl/loader_fifo.sv
// Synchronous FIFO with full/empty flags; a push and a pop in the same
// cycle are both accepted even when the FIFO is full.
module loader_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // When full, the slot being written is the one the pop frees on this edge.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// UART boot loader: announces itself, reads a LE byte count, packs program
// bytes into words, acknowledges, then streams data words through a FIFO.
// Optional checksum stage: define UART_PROGRAM_LOADER_CHECKSUM_EN.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] BOOT_BYTE  = loader_pkg::BOOT_BYTE,
  parameter logic [7:0] DONE_BYTE  = loader_pkg::DONE_BYTE,
  parameter logic [7:0] ERR_BYTE   = loader_pkg::ERR_BYTE
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        rx_ready,
  input  logic [7:0]                  rx_data,
  input  logic                        tx_busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  uart_program_loader_if.master       out_if,
  output logic                        program_loaded,
  output logic [31:0]                 program_size,
  output logic                        overflow,
  output logic                        error,
  output state_t                      state_dbg
);
  localparam int WW    = 8 * WORD_BYTES;
  localparam int BI_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SI_W  = $clog2(SIZE_BYTES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(WORD_BYTES - 1);
  localparam logic [SI_W-1:0] LAST_SIZE_IDX = SI_W'(SIZE_BYTES - 1);

  state_t          state;
  logic [31:0]     size_q;
  logic [SI_W-1:0] size_idx;
  logic [BI_W-1:0] byte_idx;
  logic [WW-1:0]   word_q;
  logic [31:0]     rem_q;
  logic            push_q;
  logic [WW-1:0]   push_word_q;
  logic            push_instr_q;
  logic            err_pend;

  logic [WW-1:0]   word_ins;
  logic [31:0]     size_ins;

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q;
  logic            error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Current word / size with the incoming byte dropped into its lane.
  always_comb begin
    word_ins = word_q;
    word_ins[8*byte_idx +: 8] = rx_data;
    size_ins = size_q;
    size_ins[8*size_idx +: 8] = rx_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_SEND_BOOT;
      tx_start     <= 1'b0;
      tx_data      <= BOOT_BYTE;
      size_q       <= '0;
      size_idx     <= '0;
      byte_idx     <= '0;
      word_q       <= '0;
      rem_q        <= '0;
      push_q       <= 1'b0;
      push_word_q  <= '0;
      push_instr_q <= 1'b0;
      err_pend     <= 1'b0;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      push_q   <= 1'b0;
      case (state)
        S_SEND_BOOT: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= BOOT_BYTE;
          size_idx <= '0;
          state    <= S_GET_SIZE;
        end
        S_GET_SIZE: if (rx_ready) begin
          size_q   <= size_ins;
          size_idx <= size_idx + SI_W'(1);
          if (size_idx == LAST_SIZE_IDX) begin
            rem_q    <= size_ins;
            byte_idx <= '0;
            word_q   <= '0;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
            state    <= (size_ins == 32'd0) ? S_SEND_DONE : S_GET_PROG;
          end
        end
        S_GET_PROG: if (rx_ready) begin
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
          sum_q <= sum_q ^ rx_data;
`endif
          rem_q <= rem_q - 32'd1;
          // Last program byte flushes a partial word; unwritten lanes are already 0.
          if (byte_idx == LAST_IDX || rem_q == 32'd1) begin
            push_q       <= 1'b1;
            push_word_q  <= word_ins;
            push_instr_q <= 1'b1;
            word_q       <= '0;
            byte_idx     <= '0;
          end else begin
            word_q   <= word_ins;
            byte_idx <= byte_idx + BI_W'(1);
          end
          if (rem_q == 32'd1) begin
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            state <= S_GET_SUM;
`else
            state <= S_SEND_DONE;
`endif
          end
        end
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
        S_GET_SUM: if (rx_ready) begin
          if (rx_data == sum_q) begin
            state <= S_SEND_DONE;
          end else begin
            error_q  <= 1'b1;
            err_pend <= 1'b1;
            state    <= S_ERROR;
          end
        end
`endif
        S_SEND_DONE: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= DONE_BYTE;
          byte_idx <= '0;
          word_q   <= '0;
          state    <= S_STREAM;
        end
        S_STREAM: if (rx_ready) begin
          if (byte_idx == LAST_IDX) begin
            push_q       <= 1'b1;
            push_word_q  <= word_ins;
            push_instr_q <= 1'b0;
            word_q       <= '0;
            byte_idx     <= '0;
          end else begin
            word_q   <= word_ins;
            byte_idx <= byte_idx + BI_W'(1);
          end
        end
        S_ERROR: if (err_pend && !tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= ERR_BYTE;
          err_pend <= 1'b0;
        end
        default: state <= S_SEND_BOOT;
      endcase
    end
  end

  logic [WW:0]      head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_acc;
  logic [CNT_W-1:0] instr_cnt;

  loader_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_q),
    .push_data ({push_instr_q, push_word_q}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign pop                 = !empty && out_if.out_ready;
  assign push_acc            = push_q && (!full || pop);
  assign out_if.out_valid    = !empty;
  assign out_if.out_data     = head[WW-1:0];
  assign out_if.out_is_instr = head[WW];
  assign program_size        = size_q;
  assign state_dbg           = state;

  // Program-word occupancy gates program_loaded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_cnt      <= '0;
      overflow       <= 1'b0;
      program_loaded <= 1'b0;
    end else begin
      instr_cnt      <= instr_cnt + CNT_W'(push_acc && push_instr_q) - CNT_W'(pop && head[WW]);
      overflow       <= overflow | (push_q && full && !pop);
      program_loaded <= (state == S_STREAM) && (instr_cnt == '0);
    end
  end

endmodule
